// File: rtl/lab3_serial_borrow_sub.sv
// Digit-serial subtractor: X - Y - Bin, DIGIT bits per clock with a registered ripple borrow.
// Optional signed-overflow output Ovf is enabled by defining LAB3_SUB_OVERFLOW_EN.
module lab3_serial_borrow_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy
`ifdef LAB3_SUB_OVERFLOW_EN
    ,
    output logic             Ovf
`endif
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
`ifdef LAB3_SUB_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    logic [31:0]      base;
    logic [DIGIT-1:0] x_dig;
    logic [DIGIT-1:0] y_dig;
    logic [DIGIT:0]   dig_res;

    always_comb begin
        base    = 32'(cnt_q) * DIGIT;
        x_dig   = x_q[base +: DIGIT];
        y_dig   = y_q[base +: DIGIT];
        // The extra top bit of the widened difference is the digit's borrow-out
        dig_res = {1'b0, x_dig} - {1'b0, y_dig} - {{DIGIT{1'b0}}, borrow_q};

        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        bout_d      = bout_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
`ifdef LAB3_SUB_OVERFLOW_EN
        ovf_d       = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d        = X;
                    y_d        = Y;
                    borrow_d   = Bin;
                    cnt_d      = '0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                diff_d[base +: DIGIT] = dig_res[DIGIT-1:0];
                borrow_d = dig_res[DIGIT];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d     = DONE;
                    bout_d      = dig_res[DIGIT];
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
`ifdef LAB3_SUB_OVERFLOW_EN
                    ovf_d = (x_q[WIDTH-1] != y_q[WIDTH-1]) &&
                            (diff_d[WIDTH-1] != x_q[WIDTH-1]);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            bout_q      <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef LAB3_SUB_OVERFLOW_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            bout_q      <= bout_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef LAB3_SUB_OVERFLOW_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign Diff      = diff_q;
    assign Bout      = bout_q;
`ifdef LAB3_SUB_OVERFLOW_EN
    assign Ovf       = ovf_q;
`endif

endmodule
